leds_pwm: RTL and testbench
===========================

# leds_pwm

Parametrised multi-channel LED driver for the icoboard LED examples, replacing fixed constant LED outputs. Each of NLEDS channels is independently programmable as off, on, PWM-dimmed or blinking through a one-cycle write port. New settings are double-buffered and take effect only at a PWM period boundary, so outputs never glitch mid-period. The block sits between a controller (or testbench) and the board LED pins.

## Interface
- NLEDS, 3: number of LED channels (1..16).
- PRESC, 12: clk cycles per PWM tick (>= 1).
- PWM_BITS, 8: PWM counter width; PWM period = 2^PWM_BITS ticks.
- BLINK_PERIODS, 64: PWM periods per blink half-cycle (>= 1).
- SW: derived, max(1, clog2(NLEDS)); select width.

- clk  in  1  system clock.
- rstn  in  1  asynchronous active-low reset.
- wr  in  1  write strobe, one cycle per write.
- sel  in  SW  channel index written when wr=1.
- mode  in  2  00 off, 01 on, 10 pwm, 11 blink.
- duty  in  PWM_BITS  PWM compare value (used in mode 10).
- leds  out  NLEDS  LED drive, bit i = channel i, registered.
- frame  out  1  one-cycle pulse on each PWM period wrap.

## Operation
- Prescaler presc counts 0..PRESC-1, wraps; tick = (presc == PRESC-1).
- PWM counter pcnt (PWM_BITS) increments on tick, wraps 2^PWM_BITS-1 -> 0.
- Wrap cycle: tick && pcnt == all-ones. frame = 1 for exactly that cycle (registered, visible the cycle after the wrap condition).
- Per channel: shadow {mode,duty} and active {mode,duty} registers.
- wr=1 with sel < NLEDS: shadow[sel] <= {mode,duty}. sel >= NLEDS: write ignored, no state change.
- On wrap cycle: active[i] <= shadow[i] for all i; a write in the same cycle is included (write-through to active).
- Blink: bcnt counts wrap cycles 0..BLINK_PERIODS-1; on wrap with bcnt == BLINK_PERIODS-1, bcnt <= 0 and phase toggles. Blink timing is global, shared by all channels.
- Next leds[i] from active[i]: 00 -> 0; 01 -> 1; 10 -> (pcnt < duty); 11 -> phase.
- duty=0 in mode 10 -> constantly 0; duty=all-ones -> high 2^PWM_BITS-1 of 2^PWM_BITS ticks.

## Timing
- Reset (rstn=0, asynchronous): presc, pcnt, bcnt, phase = 0; shadow and active = 00/0 (off); leds = 0; frame = 0. Held for whole reset.
- After rstn deasserts, counting starts on first rising clk edge.
- leds has 1-cycle latency from counter/active state (registered output, glitch-free).
- Write latency: takes effect at the next wrap, i.e. 1 to PRESC*2^PWM_BITS cycles after wr; leds reflects it one cycle after that wrap.
- Reset mid-operation: all outputs to 0 immediately, pending shadow writes lost.
- Back-to-back writes to same channel within a period: last one wins.
- PRESC=1: tick every cycle, no prescaler wait.

## Test plan
Parameters: NLEDS=3, PRESC=2, PWM_BITS=3, BLINK_PERIODS=2 (period 16 clk cycles).
- Reset: rstn low 5 cycles then high -> leds=000 and frame=0 throughout; first frame pulse 16 cycles after release, then every 16 cycles.
- Write sel=0 mode=01 at cycle 4 of a period -> leds[0] stays 0 until wrap, goes 1 one cycle after it, remains 1.
- Write sel=1 mode=10 duty=3 -> after boundary leds[1] high exactly 6 of every 16 cycles, aligned to period start; duty=0 -> always 0.
- Write sel=2 mode=11 -> leds[2] alternates 32 cycles high / 32 low, toggling only at wrap cycles.
- Write sel=3 (out of range) -> no leds change; write to sel=0 mode=00 in the wrap cycle -> leds[0] off from the next cycle.
- Assert rstn low mid-period with all channels active -> leds=000 immediately (before next clk edge); after release channels stay off until rewritten.

Source files
------------

// File: rtl/leds_pwm.sv
// leds_pwm: multi-channel LED driver (off / on / pwm / blink).
// Settings are double-buffered and applied at each PWM period wrap.
//
// Ports:
//   clk, rstn          clock, async active-low reset
//   wr, sel            one-cycle write strobe, channel index
//   mode, duty         00 off, 01 on, 10 pwm(duty), 11 blink
//   leds               registered LED drive, bit i = channel i
//   frame              one-cycle pulse after each PWM wrap
module leds_pwm #(
  parameter int NLEDS         = 3,
  parameter int PRESC         = 12,
  parameter int PWM_BITS      = 8,
  parameter int BLINK_PERIODS = 64,
  localparam int SW =
    (NLEDS > 1) ? $clog2(NLEDS) : 1
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                wr,
  input  logic [SW-1:0]       sel,
  input  logic [1:0]          mode,
  input  logic [PWM_BITS-1:0] duty,
  output logic [NLEDS-1:0]    leds,
  output logic                frame
);

  localparam int PSW =
    (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam int BW =
    (BLINK_PERIODS > 1) ?
    $clog2(BLINK_PERIODS) : 1;

  logic [PSW-1:0]      presc;
  logic [PWM_BITS-1:0] pcnt;
  logic [BW-1:0]       bcnt;
  logic                phase;
  logic                tick;
  logic                wrap;
  logic                blast;

  logic [1:0]          sm [NLEDS];
  logic [PWM_BITS-1:0] sd [NLEDS];
  logic [1:0]          am [NLEDS];
  logic [PWM_BITS-1:0] ad [NLEDS];

  logic [NLEDS-1:0]    hit;
  logic [NLEDS-1:0]    leds_nxt;

  assign tick  = (presc == PSW'(PRESC - 1));
  assign wrap  = tick && (&pcnt);
  assign blast = (bcnt == BW'(BLINK_PERIODS - 1));

  // Out-of-range sel matches no channel.
  always_comb begin
    hit = '0;
    for (int i = 0; i < NLEDS; i++) begin
      hit[i] = wr && (sel == SW'(i));
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      presc <= '0;
      pcnt  <= '0;
      bcnt  <= '0;
      phase <= 1'b0;
      frame <= 1'b0;
      leds  <= '0;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      if (tick) begin
        pcnt <= pcnt + 1'b1;
      end
      frame <= wrap;
      leds  <= leds_nxt;
      if (wrap) begin
        if (blast) begin
          bcnt  <= '0;
          phase <= ~phase;
        end else begin
          bcnt <= bcnt + 1'b1;
        end
      end
    end
  end

  // A write landing on the wrap cycle goes
  // straight through to the active copy.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NLEDS; i++) begin
        sm[i] <= 2'b00;
        sd[i] <= '0;
        am[i] <= 2'b00;
        ad[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NLEDS; i++) begin
        if (hit[i]) begin
          sm[i] <= mode;
          sd[i] <= duty;
        end
        if (wrap) begin
          am[i] <= hit[i] ? mode : sm[i];
          ad[i] <= hit[i] ? duty : sd[i];
        end
      end
    end
  end

  always_comb begin
    leds_nxt = '0;
    for (int i = 0; i < NLEDS; i++) begin
      unique case (am[i])
        2'b00: leds_nxt[i] = 1'b0;
        2'b01: leds_nxt[i] = 1'b1;
        2'b10: leds_nxt[i] = (pcnt < ad[i]);
        2'b11: leds_nxt[i] = phase;
      endcase
    end
  end

endmodule

// File: tb/tb_leds_pwm.sv
// tb_leds_pwm: scoreboard bench for leds_pwm
// (NLEDS=3, PRESC=2, PWM_BITS=3, BLINK_PERIODS=2).
module tb_leds_pwm;

  localparam int NL = 3;
  localparam int PR = 2;
  localparam int PB = 3;
  localparam int BP = 2;
  localparam int PER = PR * (1 << PB);

  logic       clk = 1'b1;
  logic       rstn;
  logic       wr;
  logic [1:0] sel;
  logic [1:0] mode;
  logic [2:0] duty;
  logic [2:0] leds;
  logic       frame;

  leds_pwm #(
    .NLEDS(NL),
    .PRESC(PR),
    .PWM_BITS(PB),
    .BLINK_PERIODS(BP)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .wr(wr),
    .sel(sel),
    .mode(mode),
    .duty(duty),
    .leds(leds),
    .frame(frame)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [3:0] expq[$];
  bit started = 0;

  int t;
  logic [1:0] sm[NL];
  logic [1:0] am[NL];
  logic [2:0] sd[NL];
  logic [2:0] ad[NL];
  int hi[NL];
  int fr[$];

  task automatic check(input string name,
                       input int got,
                       input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d",
               name, got, want);
    end
  endtask

  task automatic mclr();
    t = 0;
    for (int i = 0; i < NL; i++) begin
      sm[i] = 2'b00;
      am[i] = 2'b00;
      sd[i] = 3'd0;
      ad[i] = 3'd0;
    end
  endtask

  // One clock: observe, drive, push expected
  // {frame,leds} after the coming rising edge.
  task automatic step(input logic r,
                      input logic w,
                      input logic [1:0] s,
                      input logic [1:0] m,
                      input logic [2:0] d);
    logic [2:0] nl;
    logic wc;
    int pc;
    int ph;
    @(negedge clk);
    for (int i = 0; i < NL; i++) begin
      if (leds[i]) hi[i]++;
    end
    if (frame) fr.push_back(t);
    rstn = r;
    wr = w;
    sel = s;
    mode = m;
    duty = d;
    if (!r) begin
      mclr();
      expq.push_back(4'b0000);
    end else begin
      pc = (t / PR) % (1 << PB);
      ph = (t / (PER * BP)) % 2;
      nl = 3'b000;
      for (int i = 0; i < NL; i++) begin
        case (am[i])
          2'b01: nl[i] = 1'b1;
          2'b10: nl[i] = (pc < int'(ad[i]));
          2'b11: nl[i] = (ph != 0);
          default: nl[i] = 1'b0;
        endcase
      end
      wc = ((t % PER) == PER - 1);
      if (w && int'(s) < NL) begin
        sm[s] = m;
        sd[s] = d;
      end
      if (wc) begin
        for (int i = 0; i < NL; i++) begin
          am[i] = sm[i];
          ad[i] = sd[i];
        end
      end
      t++;
      expq.push_back({wc, nl});
    end
    started = 1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b1, 1'b0, 2'd0,
                    2'd0, 3'd0);
  endtask

  task automatic hclr();
    for (int i = 0; i < NL; i++) hi[i] = 0;
  endtask

  // Monitor: pop and compare every cycle.
  initial begin
    logic [3:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        total++;
        if ({frame, leds} !== e) begin
          bad++;
          $display("FAIL cyc t=%0d got=%b want=%b",
                   t, {frame, leds}, e);
        end
      end else if (started) begin
        total++;
        bad++;
        $display("FAIL underflow got=empty want=entry");
      end
    end
  end

  initial begin
    rstn = 1'b0;
    wr = 1'b0;
    sel = 2'd0;
    mode = 2'd0;
    duty = 3'd0;
    mclr();
    hclr();

    repeat (5) step(1'b0, 1'b0, 2'd0,
                    2'd0, 3'd0);
    fr.delete();
    idle(36);
    check("frame_first",
          fr.size() > 0 ? fr[0] : -1, 16);
    check("frame_second",
          fr.size() > 1 ? fr[1] : -1, 32);

    // t=36: cycle 4 of a period
    step(1'b1, 1'b1, 2'd0, 2'b01, 3'd0);
    idle(34);
    check("led0_on", int'(leds[0]), 1);

    step(1'b1, 1'b1, 2'd1, 2'b10, 3'd3);
    idle(20);
    hclr();
    idle(16);
    check("pwm3_hi", hi[1], 6);

    step(1'b1, 1'b1, 2'd2, 2'b11, 3'd0);
    idle(20);
    hclr();
    idle(64);
    check("blink_hi", hi[2], 32);
    check("on_hi", hi[0], 64);

    step(1'b1, 1'b1, 2'd1, 2'b10, 3'd0);
    idle(20);
    hclr();
    idle(16);
    check("pwm0_hi", hi[1], 0);

    step(1'b1, 1'b1, 2'd3, 2'b01, 3'd7);
    idle(20);

    while ((t % PER) != PER - 1) idle(1);
    step(1'b1, 1'b1, 2'd0, 2'b00, 3'd0);
    idle(3);
    check("led0_off_wrap", int'(leds[0]), 0);

    step(1'b1, 1'b1, 2'd0, 2'b01, 3'd0);
    step(1'b1, 1'b1, 2'd1, 2'b10, 3'd7);
    idle(20);
    check("led0_reon", int'(leds[0]), 1);

    step(1'b0, 1'b0, 2'd0, 2'd0, 3'd0);
    #1;
    check("async_leds", int'(leds), 0);
    check("async_frame", int'(frame), 0);
    repeat (2) step(1'b0, 1'b0, 2'd0,
                    2'd0, 3'd0);
    hclr();
    idle(40);
    check("post_rst_hi0", hi[0], 0);
    check("post_rst_hi1", hi[1], 0);
    check("post_rst_hi2", hi[2], 0);

    @(posedge clk);
    #2;
    check("queue_drained", expq.size(), 0);
    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
